// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control stage: registers the decode control word into EX,
// inserts load-use bubbles and holds EX for the multi-cycle multiplier.
module id_ex_ctrl_stage #(
    parameter int MULT_LAT   = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_reg_dst,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_2_reg,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic                  id_jump,
    input  logic                  id_flush,
    input  logic                  id_is_mult,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_reg_dst,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_2_reg,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic                  ex_jump,
    output logic                  ex_is_mult,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  mult_done
);

    typedef enum logic {RUN, MULT_HOLD} state_e;

    typedef struct packed {
        logic [1:0]            alu_op;
        logic                  reg_dst;
        logic                  branch;
        logic                  mem_read;
        logic                  mem_2_reg;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
        logic                  jump;
        logic                  is_mult;
        logic [REG_ADDR_W-1:0] rd;
    } ex_ctrl_t;

    localparam logic [3:0] LAT_M1 = 4'(MULT_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ex_ctrl_t   ctrl_q, ctrl_d;
    ex_ctrl_t   id_w;
    logic       load_use;
    logic       mult_stall;
    logic       stall;

    assign id_w = {id_alu_op, id_reg_dst, id_branch, id_mem_read,
                   id_mem_2_reg, id_mem_write, id_alu_src,
                   id_reg_write, id_jump, id_is_mult, id_rd};

    assign load_use = ctrl_q.mem_read
                    & (ctrl_q.rd != '0)
                    & ((ctrl_q.rd == id_rs1) | (ctrl_q.rd == id_rs2));

    // HOLD is entered and left together with a nonzero counter
    assign mult_stall = (state_q == MULT_HOLD);
    assign stall      = mult_stall | load_use;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        if (mult_stall) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = RUN;
            end
        end else if (load_use) begin
            ctrl_d = '0;
        end else begin
            ctrl_d = id_w;
            if (id_is_mult && (MULT_LAT > 1)) begin
                cnt_d   = LAT_M1;
                state_d = MULT_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ex_alu_op    = ctrl_q.alu_op;
    assign ex_reg_dst   = ctrl_q.reg_dst;
    assign ex_branch    = ctrl_q.branch;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_2_reg = ctrl_q.mem_2_reg;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_alu_src   = ctrl_q.alu_src;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_jump      = ctrl_q.jump;
    assign ex_is_mult   = ctrl_q.is_mult;
    assign ex_rd        = ctrl_q.rd;

    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign if_id_flush = id_flush & ~stall;
    assign mult_done   = ctrl_q.is_mult & (cnt_q == 4'd0);

endmodule
